dmem_byte_port: RTL and testbench
=================================

# dmem_byte_port

Byte-addressable data-memory responder for the RISC-V core's load/store path. Consumes the control unit's MemRead/MemWrite strobes plus the ALU address. Serves LB (sign-extended byte read) and SB (low-byte write) with a programmable access latency. Holds the core with `stall` until each access completes.

## Interface
- `ADDR_W`, 10: byte-address width; capacity is 2^ADDR_W bytes.
- `LATENCY`, 2: wait cycles per access; legal range 1..15.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `MemRead`  in  1  load request (LB); held by the core until `stall` falls.
- `MemWrite`  in  1  store request (SB); held by the core until `stall` falls.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data; only bits [7:0] are written.
- `rdata`  out  32  load result: sign-extended byte. Valid in DONE; otherwise holds its last value.
- `stall`  out  1  combinational; high while a request is present and the FSM is not in DONE.
- `err`  out  1  one-cycle pulse in DONE for an illegal or out-of-range access.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `MemRead ^ MemWrite`: capture `addr`, `wdata[7:0]` and op; load `cnt = LATENCY-1`; go to BUSY.
  - If both `MemRead` and `MemWrite` are high: go straight to DONE with the error flag set, `rdata <= 0`, no access.
  - If neither is high: stay in IDLE.
- **BUSY**
  - If the request drops (`MemRead|MemWrite == 0`): abort to IDLE. No write, `rdata` unchanged.
  - Else if `cnt != 0`: decrement `cnt`.
  - Else perform the access and go to DONE:
    - Store: write the captured byte.
    - Load: `rdata <= {{24{b[7]}}, b}`.
- **DONE**: `stall` is low and `err` shows the error flag. Unconditionally return to IDLE next cycle and clear the flag.
- **Out of range** (`addr[31:ADDR_W] != 0`): follows the normal latency, but the write is suppressed, `rdata <= 0` and `err` pulses in DONE.
- Captured values are used for the access; `addr`/`wdata` changes during BUSY are ignored.
- Request still high in the cycle after DONE: treated as a new access (the core must have advanced).

## Timing
- Reset values: state IDLE, `cnt` 0, `rdata` 0, `err` 0, error flag 0. `stall` is derived combinationally from the inputs and equals `MemRead|MemWrite` while in IDLE. Memory contents are not reset.
- Reset mid-access drops the pending store; memory is unchanged.
- Request seen at cycle 0 in IDLE:
  - BUSY covers cycles 1..LATENCY.
  - The access happens at the edge ending cycle LATENCY.
  - DONE is cycle LATENCY+1.
  - `stall` is high for cycles 0..LATENCY, i.e. LATENCY+1 cycles.
- Illegal both-high request: `stall` is high in cycle 0 only; DONE in cycle 1.
- Back-to-back accesses: the minimum issue interval is LATENCY+2 cycles.

## Configuration
- `DMEM_PERF_CNT_EN`:
  - Defined: adds outputs `rd_count` and `wr_count` (32 bits each, reset 0, wrap at 2^32). Each increments in the DONE cycle of a successful load or store respectively. Errors and aborts are not counted.
  - Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (`DMEM_IDLE`, `DMEM_BUSY`, `DMEM_DONE`);
  - the defaults `DMEM_ADDR_W_DEF = 10` and `DMEM_LATENCY_DEF = 2`;
  - the function `sext8(byte) -> 32`.
- Sub-module `dmem_byte_array` contains only the storage:
  - 2^ADDR_W x 8 array;
  - synchronous write enable;
  - combinational read of a captured index.
- `dmem_byte_port` holds the FSM, the counter, the capture registers and `rdata`.

## Test plan
- Write then read, LATENCY=2:
  - SB `addr=0x10`, `wdata=0x0000_00F3`: `stall` high for 3 cycles, `err=0`.
  - LB `0x10`: `rdata=0xFFFF_FFF3`.
- Positive byte: SB `0x7F` to `0x3FF`, then LB `0x3FF` -> `rdata=0x0000_007F`. This covers the top address.
- `MemRead` and `MemWrite` both high:
  - `stall` high for 1 cycle, `err` pulses in cycle 1, `rdata=0`.
  - Memory is unchanged (check by reading back).
- Out of range with `ADDR_W=10`:
  - SB `addr=0x400`: `err` pulses after LATENCY+1 cycles.
  - LB `0x000` still returns its prior value.
- Abort and reset mid-access:
  - Drop `MemWrite` in BUSY cycle 1: returns to IDLE, no write.
  - Assert `rst` during BUSY: state IDLE, `rdata=0`, target byte unchanged.
- With `DMEM_PERF_CNT_EN`: 3 loads + 2 stores + 1 illegal request -> `rd_count=3`, `wr_count=2`.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, defaults and helpers for the byte-wide data-memory port.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W_DEF  = 10;
  localparam int unsigned DMEM_LATENCY_DEF = 2;
  localparam int unsigned DMEM_CNT_W       = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte storage: synchronous write, combinational read of the captured index.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [7:0]        wbyte,
  output logic [7:0]        rbyte
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wbyte;
    end
  end

  assign rbyte = mem_q[idx];

endmodule

// File: rtl/dmem_byte_port.sv
// LB/SB data-memory responder with programmable latency and core stall.
// Optional DMEM_PERF_CNT_EN adds successful load/store counters.
module dmem_byte_port
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DMEM_ADDR_W_DEF,
  parameter int unsigned LATENCY = DMEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int unsigned CNT_W = DMEM_CNT_W;

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              oor_q, oor_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              inc_rd, inc_wr;
  logic [7:0]        rd_byte;
  logic              req;
  logic              unused_wdata;

  assign req          = MemRead | MemWrite;
  assign unused_wdata = ^wdata[31:8];

  dmem_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (idx_q),
    .wbyte (wbyte_q),
    .rbyte (rd_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      wbyte_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      wbyte_q <= wbyte_d;
      is_wr_q <= is_wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // err_q doubles as the error flag: set only on entry to DONE, cleared on exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    wbyte_d = wbyte_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    inc_rd  = 1'b0;
    inc_wr  = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (MemRead ^ MemWrite) begin
          idx_d   = addr[ADDR_W-1:0];
          oor_d   = |addr[31:ADDR_W];
          wbyte_d = wdata[7:0];
          is_wr_d = MemWrite;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = DMEM_BUSY;
        end else if (MemRead & MemWrite) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DMEM_DONE;
        end
      end
      DMEM_BUSY: begin
        if (!req) begin
          state_d = DMEM_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DMEM_DONE;
          if (oor_q) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (is_wr_q) begin
            mem_we = 1'b1;
            inc_wr = 1'b1;
          end else begin
            rdata_d = sext8(rd_byte);
            inc_rd  = 1'b1;
          end
        end
      end
      DMEM_DONE: begin
        state_d = DMEM_IDLE;
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  assign stall = req && (state_q != DMEM_DONE);
  assign rdata = rdata_q;
  assign err   = err_q;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Bumped on the access edge so the new count is visible in DONE.
  always_comb begin
    rd_count_d = rd_count_q + 32'(inc_rd);
    wr_count_d = wr_count_q + 32'(inc_wr);
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  logic unused_inc;
  assign unused_inc = inc_rd ^ inc_wr;
`endif

endmodule

// File: tb/tb_dmem_byte_port.sv
// Directed self-checking bench for dmem_byte_port (LATENCY=2, ADDR_W=10).
module tb_dmem_byte_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  int          ns;
  logic        e_done, e_early;
  logic [31:0] r_done;

  always #5 clk = ~clk;

  dmem_byte_port #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .err      (err)
`ifdef DMEM_PERF_CNT_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  // Issue one request at posedge+1; returns stall count, DONE-cycle err/rdata.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int n_stall,
                        output logic err_done, output logic err_early,
                        output logic [31:0] rd_done);
    MemRead = rd; MemWrite = wr; addr = a; wdata = d;
    n_stall = 0; err_done = 1'b0; err_early = 1'b0; rd_done = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall) begin
        n_stall++;
        if (err) err_early = 1'b1;
        @(posedge clk); #1;
      end else begin
        err_done = err;
        rd_done  = rdata;
        break;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata); else n_pass++;
    MemRead = 1'b1; #1;
    n_total++; if (stall !== 1'b1) $display("FAIL reset_stall_req got %b want 1", stall); else n_pass++;
    MemRead = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b1, 32'h10, 32'h0000_00F3, ns, e_done, e_early, r_done);
    n_total++; if (ns != 3) $display("FAIL sb_stall_cycles got %0d want 3", ns); else n_pass++;
    n_total++; if ({e_done, e_early} !== 2'b00) $display("FAIL sb_err got %b want 00", {e_done, e_early}); else n_pass++;
    access(1'b1, 1'b0, 32'h10, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if (ns != 3) $display("FAIL lb_stall_cycles got %0d want 3", ns); else n_pass++;
    n_total++; if (r_done !== 32'hFFFF_FFF3) $display("FAIL lb_neg_rdata got %h want ffffff f3", r_done); else n_pass++;
    n_total++; if (e_done !== 1'b0) $display("FAIL lb_err got %b want 0", e_done); else n_pass++;
  endtask

  task automatic test_top_addr();
    access(1'b0, 1'b1, 32'h3FF, 32'hAAAA_AA7F, ns, e_done, e_early, r_done);
    access(1'b1, 1'b0, 32'h3FF, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if (r_done !== 32'h0000_007F) $display("FAIL lb_top_rdata got %h want 0000007f", r_done); else n_pass++;
  endtask

  task automatic test_illegal();
    access(1'b1, 1'b1, 32'h10, 32'h0000_0055, ns, e_done, e_early, r_done);
    n_total++; if (ns != 1) $display("FAIL both_stall_cycles got %0d want 1", ns); else n_pass++;
    n_total++; if (e_done !== 1'b1) $display("FAIL both_err got %b want 1", e_done); else n_pass++;
    n_total++; if (r_done !== 32'h0) $display("FAIL both_rdata got %h want 0", r_done); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL both_err_pulse got %b want 0 after DONE", err); else n_pass++;
    access(1'b1, 1'b0, 32'h10, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if (r_done !== 32'hFFFF_FFF3) $display("FAIL both_mem_kept got %h want fffffff3", r_done); else n_pass++;
  endtask

  task automatic test_out_of_range();
    access(1'b0, 1'b1, 32'h000, 32'h0000_0021, ns, e_done, e_early, r_done);
    access(1'b0, 1'b1, 32'h400, 32'h0000_0099, ns, e_done, e_early, r_done);
    n_total++; if (ns != 3) $display("FAIL oor_stall_cycles got %0d want 3", ns); else n_pass++;
    n_total++; if ({e_done, e_early} !== 2'b10) $display("FAIL oor_err got %b want 10", {e_done, e_early}); else n_pass++;
    n_total++; if (r_done !== 32'h0) $display("FAIL oor_rdata got %h want 0", r_done); else n_pass++;
    access(1'b1, 1'b0, 32'h000, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if (r_done !== 32'h0000_0021) $display("FAIL oor_alias got %h want 00000021", r_done); else n_pass++;
    access(1'b1, 1'b0, 32'h8000_0000, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if ({e_done, r_done} !== {1'b1, 32'h0}) $display("FAIL oor_load got err=%b rdata=%h want err=1 rdata=0", e_done, r_done); else n_pass++;
  endtask

  task automatic test_capture();
    MemRead = 1'b1; addr = 32'h10;
    @(posedge clk); #1;
    addr = 32'h3FF;
    for (int i = 0; i < 20 && stall; i++) begin
      @(posedge clk); #1;
    end
    n_total++; if (rdata !== 32'hFFFF_FFF3) $display("FAIL capture_addr got %h want fffffff3", rdata); else n_pass++;
    MemRead = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] obs;
    obs = '0;
    MemRead = 1'b1; addr = 32'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs[7-i] = stall;
      @(posedge clk); #1;
    end
    MemRead = 1'b0;
    n_total++; if (obs !== 8'b1110_1110) $display("FAIL b2b_stall_pattern got %b want 11101110", obs); else n_pass++;
    n_total++; if (rdata !== 32'hFFFF_FFF3) $display("FAIL b2b_rdata got %h want fffffff3", rdata); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    access(1'b0, 1'b1, 32'h20, 32'h0000_0011, ns, e_done, e_early, r_done);
    access(1'b1, 1'b0, 32'h20, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if (r_done !== 32'h0000_0011) $display("FAIL abort_pre got %h want 00000011", r_done); else n_pass++;
    MemWrite = 1'b1; addr = 32'h20; wdata = 32'h0000_00AB;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    @(negedge clk);
    n_total++; if (stall !== 1'b0) $display("FAIL abort_stall got %b want 0", stall); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({err, rdata} !== {1'b0, 32'h11}) $display("FAIL abort_outputs got err=%b rdata=%h want err=0 rdata=11", err, rdata); else n_pass++;
    access(1'b1, 1'b0, 32'h20, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if (r_done !== 32'h0000_0011) $display("FAIL abort_no_write got %h want 00000011", r_done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    access(1'b0, 1'b1, 32'h30, 32'h0000_0005, ns, e_done, e_early, r_done);
    access(1'b1, 1'b0, 32'h30, 32'h0, ns, e_done, e_early, r_done);
    MemWrite = 1'b1; addr = 32'h30; wdata = 32'h0000_00EE;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    n_total++; if (rdata !== 32'h0) $display("FAIL rstmid_rdata got %h want 0", rdata); else n_pass++;
    n_total++; if ({stall, err} !== 2'b10) $display("FAIL rstmid_idle got stall,err=%b want 10", {stall, err}); else n_pass++;
    MemWrite = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h30, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if (r_done !== 32'h0000_0005) $display("FAIL rstmid_mem got %h want 00000005", r_done); else n_pass++;
  endtask

`ifdef DMEM_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h10, 32'h0, ns, e_done, e_early, r_done);
    access(1'b0, 1'b1, 32'h40, 32'h1, ns, e_done, e_early, r_done);
    access(1'b1, 1'b0, 32'h40, 32'h0, ns, e_done, e_early, r_done);
    access(1'b1, 1'b1, 32'h40, 32'h0, ns, e_done, e_early, r_done);
    access(1'b0, 1'b1, 32'h41, 32'h2, ns, e_done, e_early, r_done);
    access(1'b1, 1'b0, 32'h41, 32'h0, ns, e_done, e_early, r_done);
    n_total++; if (rd_count !== 32'd3) $display("FAIL perf_rd got %0d want 3", rd_count); else n_pass++;
    n_total++; if (wr_count !== 32'd2) $display("FAIL perf_wr got %0d want 2", wr_count); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_top_addr();
    test_illegal();
    test_out_of_range();
    test_capture();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef DMEM_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
